// File: rtl/ped_crossing_controller_if.sv
// Signal bundle between the vehicle-light source and the pedestrian crossing controller.
// The master drives the light code and button; the slave drives the lamps and status.
interface ped_crossing_controller_if #(
  parameter int CNT_W = 4
);
  logic [2:0]       light;
  logic             ped_button;
  logic             walk;
  logic             dont_walk;
  logic             req_pending;
  logic [CNT_W-1:0] countdown;
  logic             fault;

  modport master (
    output light, ped_button,
    input  walk, dont_walk, req_pending, countdown, fault
  );

  modport slave (
    input  light, ped_button,
    output walk, dont_walk, req_pending, countdown, fault
  );
endinterface

// File: rtl/ped_crossing_controller.sv
// Pedestrian crossing controller: grants WALK at vehicle-red onset, then a flashing
// DONT_WALK clearance with countdown; early red exit aborts, illegal light codes latch a fault.
module ped_crossing_controller #(
  parameter int WALK_CYCLES  = 3,
  parameter int FLASH_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input logic                      clk,
  input logic                      reset,
  ped_crossing_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WALK, FLASH} state_t;

  localparam logic [2:0]       RED         = 3'b100;
  localparam logic [2:0]       YELLOW      = 3'b010;
  localparam logic [2:0]       GREEN       = 3'b001;
  localparam logic [CNT_W-1:0] TOTAL       = CNT_W'(WALK_CYCLES + FLASH_CYCLES);
  localparam logic [CNT_W-1:0] FLASH_START = CNT_W'(FLASH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [2:0]       light_prev_reg, light_prev_next;
  logic             req_reg, req_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             walk_reg, walk_next;
  logic             dw_reg, dw_next;
  logic             fault_reg, fault_next;

  logic is_red;
  logic illegal;
  logic red_onset;

  assign is_red    = (bus.light == RED);
  assign illegal   = !(bus.light inside {RED, YELLOW, GREEN});
  assign red_onset = is_red && (light_prev_reg != RED);

  // light_prev resets to red so a red already present at reset release is not an onset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      light_prev_reg <= RED;
      req_reg        <= 1'b0;
      cnt_reg        <= '0;
      walk_reg       <= 1'b0;
      dw_reg         <= 1'b1;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      light_prev_reg <= light_prev_next;
      req_reg        <= req_next;
      cnt_reg        <= cnt_next;
      walk_reg       <= walk_next;
      dw_reg         <= dw_next;
      fault_reg      <= fault_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    light_prev_next = bus.light;
    req_next        = req_reg;
    cnt_next        = cnt_reg;
    walk_next       = walk_reg;
    dw_next         = dw_reg;
    fault_next      = fault_reg;

    if (fault_reg || illegal) begin
      // Fault outranks abort and grant; the controller stays parked in safe DONT_WALK.
      fault_next = 1'b1;
      state_next = IDLE;
      req_next   = 1'b0;
      cnt_next   = '0;
      walk_next  = 1'b0;
      dw_next    = 1'b1;
    end else begin
      req_next = req_reg | bus.ped_button;
      unique case (state_reg)
        IDLE: begin
          cnt_next  = '0;
          walk_next = 1'b0;
          dw_next   = 1'b1;
          if (red_onset && req_next) begin
            state_next = WALK;
            req_next   = 1'b0;
            cnt_next   = TOTAL;
            walk_next  = 1'b1;
            dw_next    = 1'b0;
          end
        end
        WALK: begin
          if (!is_red) begin
            state_next = IDLE;
            cnt_next   = '0;
            walk_next  = 1'b0;
            dw_next    = 1'b1;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
            // The countdown itself marks the last WALK cycle, so no separate phase timer.
            if (cnt_reg == FLASH_START) begin
              state_next = FLASH;
              walk_next  = 1'b0;
              dw_next    = 1'b1;
            end
          end
        end
        FLASH: begin
          if (!is_red || cnt_reg == CNT_ONE) begin
            state_next = IDLE;
            cnt_next   = '0;
            walk_next  = 1'b0;
            dw_next    = 1'b1;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
            dw_next  = ~dw_reg;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          walk_next  = 1'b0;
          dw_next    = 1'b1;
        end
      endcase
    end
  end

  assign bus.walk        = walk_reg;
  assign bus.dont_walk   = dw_reg;
  assign bus.req_pending = req_reg;
  assign bus.countdown   = cnt_reg;
  assign bus.fault       = fault_reg;

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Scoreboard bench for ped_crossing_controller: the driver queues hand-computed
// expected outputs, independent monitors pop and compare after each edge / reset assertion.
module tb_ped_crossing_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    logic       walk;
    logic       dw;
    logic       req;
    logic [3:0] cnt;
    logic       fault;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  ped_crossing_controller_if #(.CNT_W(4)) bus ();

  ped_crossing_controller #(
    .WALK_CYCLES (3),
    .FLASH_CYCLES(2),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic [7:0] act, req;
    act = {bus.walk, bus.dont_walk, bus.req_pending, bus.countdown, bus.fault};
    req = {e.walk, e.dw, e.req, e.cnt, e.fault};
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got walk=%b dw=%b req=%b cnt=%0d fault=%b, want walk=%b dw=%b req=%b cnt=%0d fault=%b",
               e.name, bus.walk, bus.dont_walk, bus.req_pending, bus.countdown, bus.fault,
               e.walk, e.dw, e.req, e.cnt, e.fault);
    end else begin
      $display("ok   %s: walk=%b dw=%b req=%b cnt=%0d fault=%b",
               e.name, bus.walk, bus.dont_walk, bus.req_pending, bus.countdown, bus.fault);
    end
  endtask

  // Clocked outputs are checked 1 time unit after the edge that produced them.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(exp_q.pop_front());
  end

  // Asynchronous reset is checked without waiting for any clock edge.
  always @(posedge reset) begin
    #1;
    if (exp_q.size() > 0) check(exp_q.pop_front());
  end

  function automatic exp_t mk(input logic w, input logic d, input logic r,
                              input logic [3:0] c, input logic f, input string n);
    exp_t e;
    e.walk = w; e.dw = d; e.req = r; e.cnt = c; e.fault = f; e.name = n;
    return e;
  endfunction

  // Called on a falling edge: drive inputs, queue the expectation for the next rising edge.
  task automatic step(input logic [2:0] l, input logic b, input logic w, input logic d,
                      input logic r, input logic [3:0] c, input logic f, input string n);
    reset = 1'b0;
    bus.light = l;
    bus.ped_button = b;
    exp_q.push_back(mk(w, d, r, c, f, n));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] l, input string n);
    bus.light = l;
    bus.ped_button = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, n));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.light = R;
    bus.ped_button = 1'b0;
    @(negedge clk);
    do_reset(R, "reset_initial");

    // Basic grant
    step(G, 1, 0, 1, 1, 0, 0, "t1_press_green");
    step(G, 0, 0, 1, 1, 0, 0, "t1_green_hold");
    step(Y, 0, 0, 1, 1, 0, 0, "t1_yellow_hold");
    step(R, 0, 1, 0, 0, 5, 0, "t1_walk_cnt5");
    step(R, 0, 1, 0, 0, 4, 0, "t1_walk_cnt4");
    step(R, 0, 1, 0, 0, 3, 0, "t1_walk_cnt3");
    step(R, 0, 0, 1, 0, 2, 0, "t1_flash_cnt2");
    step(R, 0, 0, 0, 0, 1, 0, "t1_flash_cnt1");
    step(G, 0, 0, 1, 0, 0, 0, "t1_idle");

    // Late request, then abort on the 2nd WALK cycle
    step(R, 0, 0, 1, 0, 0, 0, "t2_onset_noreq");
    step(R, 1, 0, 1, 1, 0, 0, "t2_late_press");
    step(R, 0, 0, 1, 1, 0, 0, "t2_no_walk_mid_red");
    step(G, 0, 0, 1, 1, 0, 0, "t2_held_green");
    step(Y, 0, 0, 1, 1, 0, 0, "t2_held_yellow");
    step(R, 0, 1, 0, 0, 5, 0, "t2_walk_next_onset");
    step(R, 0, 1, 0, 0, 4, 0, "t4_walk_cnt4");
    step(G, 0, 0, 1, 0, 0, 0, "t4_abort");
    step(G, 0, 0, 1, 0, 0, 0, "t4_no_flash");

    // Onset press, queued press during WALK, reset mid-FLASH
    step(Y, 0, 0, 1, 0, 0, 0, "t3_yellow");
    step(R, 1, 1, 0, 0, 5, 0, "t3_onset_press");
    step(R, 1, 1, 0, 1, 4, 0, "t3_queue_in_walk");
    step(R, 0, 1, 0, 1, 3, 0, "t3_walk_cnt3");
    step(R, 0, 0, 1, 1, 2, 0, "t3_flash_cnt2");
    do_reset(R, "t6_reset_mid_flash");
    step(R, 1, 0, 1, 1, 0, 0, "t6_release_press_no_onset");

    // Queued request granted, then fault mid-WALK
    step(R, 0, 0, 1, 1, 0, 0, "t5_red_hold");
    step(G, 0, 0, 1, 1, 0, 0, "t5_green");
    step(Y, 0, 0, 1, 1, 0, 0, "t5_yellow");
    step(R, 0, 1, 0, 0, 5, 0, "t5_walk_cnt5");
    step(R, 0, 1, 0, 0, 4, 0, "t5_walk_cnt4");
    step(3'b110, 0, 0, 1, 0, 0, 1, "t5_illegal_code");
    step(G, 1, 0, 1, 0, 0, 1, "t5_press_ignored_g");
    step(Y, 1, 0, 1, 0, 0, 1, "t5_press_ignored_y");
    step(R, 1, 0, 1, 0, 0, 1, "t5_no_grant_onset");
    step(R, 0, 0, 1, 0, 0, 1, "t5_fault_sticky");
    do_reset(G, "t5_reset_clears_fault");
    step(G, 0, 0, 1, 0, 0, 0, "t5_after_reset");

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ped_crossing_controller.md
Name: ped_crossing_controller

Overview:
- Downstream consumer of the vehicle traffic-light FSM output (`light[2:0]`: 100=red, 010=yellow, 001=green).
- Latches pedestrian button requests and grants a WALK interval aligned to the start of a vehicle-red phase.
- After WALK, runs a flashing DONT_WALK clearance interval and a countdown display.
- Leaving red early, or seeing an illegal light code, forces a safe solid DONT_WALK; an illegal code also sets a sticky fault.

Parameters:
- WALK_CYCLES, 3, cycles of solid WALK (>=1).
- FLASH_CYCLES, 2, cycles of flashing DONT_WALK clearance (>=1).
- CNT_W, 4, countdown width; must hold WALK_CYCLES+FLASH_CYCLES.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- light  input  3  vehicle light code from upstream FSM; legal values 100, 010, 001.
- ped_button  input  1  pedestrian request, level, sampled every rising edge.
- walk  output  1  WALK lamp.
- dont_walk  output  1  DONT_WALK lamp.
- req_pending  output  1  request latched, not yet served.
- countdown  output  CNT_W  remaining crossing cycles, 0 when idle.
- fault  output  1  sticky illegal-light-code flag.

Behaviour:
- Clock and reset:
  - Clock is clk; reset is asynchronous, active-high.
  - Reset values: walk=0, dont_walk=1, req_pending=0, countdown=0, fault=0, state=IDLE, light_prev=100.
  - light_prev resets to 100 so that red present right out of reset is not treated as red onset.
- All outputs are registered. Inputs sampled at edge N take effect on outputs after edge N.
- red_onset = (light==100) && (light_prev!=100). light_prev <= light every cycle.
- Request latch:
  - req_pending <= 1 on any edge with ped_button=1, including during WALK/FLASH; this queues the next crossing.
  - Cleared only on the edge that enters WALK.
- IDLE state:
  - Outputs: walk=0, dont_walk=1, countdown=0.
  - Go to WALK on red_onset && (req_pending || ped_button). A press on the onset edge itself counts.
  - A request arriving mid-red waits for the next red onset.
- WALK state:
  - Outputs: walk=1, dont_walk=0.
  - countdown loads WALK_CYCLES+FLASH_CYCLES on entry and decrements by 1 every edge.
  - After WALK_CYCLES cycles, go to FLASH.
- FLASH state:
  - Outputs: walk=0; dont_walk=1 on the first FLASH cycle, toggling every cycle after that.
  - countdown keeps decrementing and reaches 1 in the last FLASH cycle.
  - After FLASH_CYCLES cycles, go to IDLE: countdown=0, dont_walk=1 solid.
- Early-exit abort:
  - If light != 100 on any edge while in WALK or FLASH, go to IDLE on that edge: walk=0, dont_walk=1, countdown=0.
  - The served request stays cleared.
  - This takes priority over normal sequencing.
- Fault:
  - light not in {100, 010, 001} on any edge sets fault=1 (sticky until reset).
  - Forces state=IDLE, walk=0, dont_walk=1, countdown=0, req_pending=0.
  - While fault=1, button presses are ignored and no WALK is granted.
  - Fault check takes priority over abort and over grant.
- Simultaneous events: a press on the same edge as WALK entry is consumed by that grant (req_pending stays 0).
- Reset mid-crossing: outputs return to reset values immediately (asynchronous); the pending request is lost.
- countdown never underflows; it saturates at 0 in IDLE.

Test Plan:
(All scenarios use default parameters.)
1. Basic grant: press ped_button 1 cycle during green; light sequence green->yellow->red(5 cycles).
   - req_pending=1 until red onset.
   - Then walk=1 for 3 cycles with countdown 5,4,3.
   - Then dont_walk 1,0 with countdown 2,1.
   - Then IDLE: dont_walk=1, countdown=0, req_pending=0.
2. Late request: press on the 2nd red cycle.
   - No walk in this red phase; req_pending held through green/yellow.
   - WALK begins after the next red onset.
3. Onset press: ped_button=1 only on the red-onset edge with req_pending=0.
   - walk=1 on the next cycle; req_pending stays 0.
4. Abort: enter WALK, then drive light=001 on the 2nd WALK cycle.
   - Next outputs: walk=0, dont_walk=1, countdown=0.
   - No FLASH phase occurs.
5. Fault: drive light=110 for 1 cycle mid-WALK, then legal codes with button presses.
   - fault=1 sticky, walk=0, dont_walk=1, req_pending=0, no further grants until reset.
   - After reset, fault=0.
6. Reset behaviour:
   - Release reset with light=100 and ped_button=1: no grant (no onset); req_pending=1.
   - Assert reset mid-FLASH: outputs return to reset values immediately.
